// File: rtl/ser_pkg.sv
// Shared FSM state type, line levels and counter sizing for the two-lane serializer.
package ser_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, GAP} ser_state_t;

    localparam logic START_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b0;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ser_lane_shift.sv
// One serial lane: parallel-load shift register presenting its MSB; shifts left.
module ser_lane_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_sh;

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            r_sh <= '0;
        else if (i_load)
            r_sh <= i_data;
        else if (i_shift)
            r_sh <= {r_sh[WIDTH-2:0], 1'b0};
    end

    assign o_msb = r_sh[WIDTH-1];

endmodule

// File: rtl/dual_lane_serializer.sv
// Two-lane lockstep serializer: start bit, WIDTH data bits MSB-first, then an idle gap.
module dual_lane_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data_a,
    input  logic [WIDTH-1:0] s_data_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES + 1);

    ser_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [GW-1:0] r_gcnt, w_gcnt_nxt;
    logic r_ser_a, r_ser_b, r_busy;
    logic w_ser_a_nxt, w_ser_b_nxt;
    logic w_load, w_shift;
    logic w_msb_a, w_msb_b;

    ser_lane_shift #(.WIDTH(WIDTH)) u_lane_a (
        .clk     (clk),
        .arst    (arst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (s_data_a),
        .o_msb   (w_msb_a)
    );

    ser_lane_shift #(.WIDTH(WIDTH)) u_lane_b (
        .clk     (clk),
        .arst    (arst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (s_data_b),
        .o_msb   (w_msb_b)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_ser_a <= IDLE_LEVEL;
            r_ser_b <= IDLE_LEVEL;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gcnt  <= w_gcnt_nxt;
            r_ser_a <= w_ser_a_nxt;
            r_ser_b <= w_ser_b_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    // Serial outputs are registered, so each branch computes the level for the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gcnt_nxt  = r_gcnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_ser_a_nxt = IDLE_LEVEL;
        w_ser_b_nxt = IDLE_LEVEL;
        case (r_state)
            IDLE: begin
                if (s_valid) begin
                    w_state_nxt = START;
                    w_load      = 1'b1;
                    w_ser_a_nxt = START_LEVEL;
                    w_ser_b_nxt = START_LEVEL;
                end
            end
            START: begin
                w_state_nxt = DATA;
                w_cnt_nxt   = CW'(WIDTH - 1);
                w_ser_a_nxt = w_msb_a;
                w_ser_b_nxt = w_msb_b;
                w_shift     = 1'b1;
            end
            DATA: begin
                if (r_cnt == '0) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = GAP;
                        w_gcnt_nxt  = GW'(GAP_CYCLES - 1);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                    w_ser_a_nxt = w_msb_a;
                    w_ser_b_nxt = w_msb_b;
                    w_shift     = 1'b1;
                end
            end
            GAP: begin
                if (r_gcnt == '0)
                    w_state_nxt = IDLE;
                else
                    w_gcnt_nxt = r_gcnt - 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign s_ready = (r_state == IDLE);
    assign ser_a   = r_ser_a;
    assign ser_b   = r_ser_b;
    assign busy    = r_busy;

endmodule

// File: tb/tb_dual_lane_serializer.sv
// Scoreboard bench for dual_lane_serializer: an 8-bit/gap-2 build and a 4-bit/gap-0 build.
module tb_dual_lane_serializer;

    logic clk  = 1'b0;
    logic arst = 1'b1;

    logic       v8 = 1'b0, r8, busy8, sa8, sb8;
    logic [7:0] da8 = '0, db8 = '0;
    logic       v4 = 1'b0, r4, busy4, sa4, sb4;
    logic [3:0] da4 = '0, db4 = '0;

    int checks   = 0;
    int failures = 0;

    logic [1:0] q8[$];
    logic [1:0] q4[$];
    logic [1:0] e8, e4;

    always #5 clk = ~clk;

    dual_lane_serializer #(.WIDTH(8), .GAP_CYCLES(2)) dut8 (
        .clk(clk), .arst(arst), .s_valid(v8), .s_ready(r8),
        .s_data_a(da8), .s_data_b(db8), .ser_a(sa8), .ser_b(sb8), .busy(busy8)
    );

    dual_lane_serializer #(.WIDTH(4), .GAP_CYCLES(0)) dut4 (
        .clk(clk), .arst(arst), .s_valid(v4), .s_ready(r4),
        .s_data_a(da4), .s_data_b(db4), .ser_a(sa4), .ser_b(sb4), .busy(busy4)
    );

    // Per-cycle scoreboard: every busy cycle consumes one expected {a,b} pair, idle cycles must be 0.
    always @(negedge clk) begin
        if (arst) begin
            q8.delete();
        end else begin
            checks++;
            if (busy8) begin
                if (q8.size() == 0) begin
                    failures++;
                    $display("FAIL sb8_extra busy=1 ser=%b%b but no frame expected", sa8, sb8);
                end else begin
                    e8 = q8.pop_front();
                    if ({sa8, sb8} !== e8) begin
                        failures++;
                        $display("FAIL sb8_bit got=%b%b want=%b at %0t", sa8, sb8, e8, $time);
                    end
                end
            end else if ({sa8, sb8} !== 2'b00) begin
                failures++;
                $display("FAIL sb8_idle got=%b%b want=00 at %0t", sa8, sb8, $time);
            end
            if (v8 && r8) begin
                q8.push_back(2'b11);
                for (int i = 7; i >= 0; i--) q8.push_back({da8[i], db8[i]});
                repeat (2) q8.push_back(2'b00);
            end
        end
    end

    always @(negedge clk) begin
        if (arst) begin
            q4.delete();
        end else begin
            checks++;
            if (busy4) begin
                if (q4.size() == 0) begin
                    failures++;
                    $display("FAIL sb4_extra busy=1 ser=%b%b but no frame expected", sa4, sb4);
                end else begin
                    e4 = q4.pop_front();
                    if ({sa4, sb4} !== e4) begin
                        failures++;
                        $display("FAIL sb4_bit got=%b%b want=%b at %0t", sa4, sb4, e4, $time);
                    end
                end
            end else if ({sa4, sb4} !== 2'b00) begin
                failures++;
                $display("FAIL sb4_idle got=%b%b want=00 at %0t", sa4, sb4, $time);
            end
            if (v4 && r4) begin
                q4.push_back(2'b11);
                for (int i = 3; i >= 0; i--) q4.push_back({da4[i], db4[i]});
            end
        end
    end

    task automatic drain8;
        int n = 0;
        while ((q8.size() != 0 || busy8) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL drain8 pending=%0d busy=%b want empty and idle", q8.size(), busy8);
        end
    endtask

    task automatic drain4;
        int n = 0;
        while ((q4.size() != 0 || busy4) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL drain4 pending=%0d busy=%b want empty and idle", q4.size(), busy4);
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #2;
        arst = 1'b1;
        #1;
        checks++;
        if ({sa8, sb8, busy8, sa4, sb4, busy4} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outs got=%b want=000000", {sa8, sb8, busy8, sa4, sb4, busy4});
        end
        #1 arst = 1'b0;
        #1;
        checks++;
        if ({r8, r4} !== 2'b11) begin
            failures++;
            $display("FAIL reset_ready got=%b want=11", {r8, r4});
        end
    endtask

    task automatic test_single;
        @(posedge clk); #1;
        da8 = 8'hA5; db8 = 8'h3C; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        checks++;
        if ({r8, busy8} !== 2'b01) begin
            failures++;
            $display("FAIL single_t1 ready,busy got=%b want=01", {r8, busy8});
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (r8 !== 1'b0) begin
            failures++;
            $display("FAIL single_t11 ready got=%b want=0", r8);
        end
        @(posedge clk); #1;
        checks++;
        if (r8 !== 1'b1) begin
            failures++;
            $display("FAIL single_t12 ready got=%b want=1", r8);
        end
        drain8();
    endtask

    task automatic test_back_to_back;
        int  rise2 = -1;
        logic prevb;
        @(posedge clk); #1;
        da8 = 8'hFF; db8 = 8'h00; v8 = 1'b1;
        @(posedge clk); #1;
        da8 = 8'h00; db8 = 8'hFF;
        prevb = busy8;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (busy8 && !prevb) begin
                rise2 = k;
                break;
            end
            prevb = busy8;
        end
        v8 = 1'b0;
        checks++;
        if (rise2 != 12) begin
            failures++;
            $display("FAIL b2b_period got=%0d want=12", rise2);
        end
        drain8();
    endtask

    task automatic test_input_change;
        @(posedge clk); #1;
        da8 = 8'hA5; db8 = 8'h3C; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k == 3) da8 = 8'h00;
            checks++;
            if (r8 !== 1'b0) begin
                failures++;
                $display("FAIL chg_ready t+%0d got=%b want=0", k, r8);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (r8 !== 1'b1) begin
            failures++;
            $display("FAIL chg_ready t+12 got=%b want=1", r8);
        end
        drain8();
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        da8 = 8'hFF; db8 = 8'hFF; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        arst = 1'b1;
        #1;
        checks++;
        if ({sa8, sb8, busy8} !== 3'b000) begin
            failures++;
            $display("FAIL rstmid_outs got=%b want=000", {sa8, sb8, busy8});
        end
        @(negedge clk); #1;
        arst = 1'b0;
        @(posedge clk); #1;
        da8 = 8'h81; db8 = 8'h7E; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_restart busy got=%b want=1", busy8);
        end
        drain8();
    endtask

    task automatic test_gap0;
        int  rise2 = -1;
        logic prevb;
        @(posedge clk); #1;
        da4 = 4'h9; db4 = 4'h6; v4 = 1'b1;
        @(posedge clk); #1;
        prevb = busy4;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (busy4 && !prevb) begin
                rise2 = k;
                break;
            end
            prevb = busy4;
        end
        v4 = 1'b0;
        checks++;
        if (rise2 != 6) begin
            failures++;
            $display("FAIL gap0_period got=%0d want=6", rise2);
        end
        drain4();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_input_change();
        test_reset_mid();
        test_gap0();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_lane_serializer.md
Name: dual_lane_serializer

Overview:
- Transmit-side counterpart of the team's two-lane serial capture path.
- Accepts a pair of parallel words over a valid/ready handshake and shifts them out MSB-first on two synchronous serial lanes, ser_a and ser_b, in lockstep.
- Each frame is a start bit, WIDTH data bits, then a fixed idle gap. The downstream shift-register receiver can therefore frame words.

Parameters:
- WIDTH, 8, data bits per lane per frame; legal range 2..32.
- GAP_CYCLES, 2, idle (0) cycles driven after the last data bit; legal range 0..15.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- arst  input  1  reset, asynchronous, active-high.
- s_valid  input  1  upstream word pair valid.
- s_ready  output  1  block can accept a word pair.
- s_data_a  input  WIDTH  word for lane A.
- s_data_b  input  WIDTH  word for lane B.
- ser_a  output  1  lane A serial out, registered.
- ser_b  output  1  lane B serial out, registered.
- busy  output  1  frame in progress (state != IDLE), registered.

Behaviour:
- Reset (arst=1, asynchronous):
  - state=IDLE; ser_a=0, ser_b=0, busy=0; shift registers and counter cleared.
  - s_ready=1 as soon as arst deasserts.
- s_ready is combinational: s_ready = (state==IDLE). It does not depend on s_valid.
- Accept occurs when s_valid && s_ready at a rising edge (cycle T):
  - s_data_a and s_data_b are loaded into internal shift registers sh_a and sh_b.
  - state goes to START; busy=1 from T+1.
  - s_data_* are sampled only in the accept cycle; later changes are ignored.
- State START, cycle T+1: ser_a=1, ser_b=1 (start bit). Next state DATA, with bit counter = WIDTH-1.
- State DATA, cycles T+2 .. T+1+WIDTH:
  - ser_a=sh_a[WIDTH-1] and ser_b=sh_b[WIDTH-1]; registers shift left by one each cycle.
  - Counter decrements; leave DATA after the bit driven with counter=0.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- State GAP, cycles T+2+WIDTH .. T+1+WIDTH+GAP_CYCLES:
  - ser_a=0, ser_b=0; gap counter runs GAP_CYCLES-1 down to 0, then IDLE.
- State IDLE: ser_a=0, ser_b=0, busy=0.
- Frame period:
  - Minimum accept-to-accept spacing = WIDTH+GAP_CYCLES+2 cycles (the IDLE accept cycle is included).
  - With GAP_CYCLES=0, a new start bit can directly follow an IDLE cycle after the last data bit.
- Both lanes always share state and counter. No lane skew is permitted.
- Data value 0 with start bit: a frame of all-zero data is still distinguishable because the start bit is 1.
- s_valid held high continuously produces back-to-back frames at the minimum period, with no dropped or duplicated words.
- s_valid deasserted during a frame has no effect. The in-flight frame always completes.
- arst mid-frame:
  - Outputs go to 0 immediately and the frame is abandoned.
  - After release, the next accepted word starts a clean frame.
- Counter widths: $clog2(WIDTH) and $clog2(GAP_CYCLES+1), minimum 1 bit each. No wrap occurs in legal ranges.

Decomposition:
- Shared package ser_pkg contains:
  - typedef enum logic [1:0] {IDLE, START, DATA, GAP} ser_state_t;
  - localparam START_LEVEL=1'b1, IDLE_LEVEL=1'b0.
- One natural sub-module, ser_lane_shift: a WIDTH-bit load/shift register with MSB output.
  - Instantiated twice (lanes A and B), both driven by the common FSM.

Test Plan:
- Reset: assert arst mid-simulation with no clock edge.
  - Expect ser_a=ser_b=0, busy=0 immediately; s_ready=1 after release.
- Single frame, WIDTH=8, GAP=2: accept s_data_a=8'hA5, s_data_b=8'h3C at T.
  - ser_a expected from T+1: 1,1,0,1,0,0,1,0,1,0,0.
  - ser_b expected from T+1: 1,0,0,1,1,1,1,0,0,0,0.
  - s_ready high again at T+12.
- Back-to-back: s_valid held high with words 8'hFF/8'h00 then 8'h00/8'hFF.
  - Expect the second start bit exactly 12 cycles after the first; no duplicates.
- Input change mid-frame: alter s_data_a at T+3 to 8'h00.
  - Expect serial output still to be 8'hA5.
  - s_ready=0 from T+1 to T+11.
- Reset mid-frame: assert arst at T+5.
  - Expect immediate ser=0, busy=0.
  - Next accept of 8'h81/8'h7E yields a correct full frame.
- GAP_CYCLES=0 build, WIDTH=4: two consecutive accepts of 4'h9/4'h6.
  - Expect period 6 cycles: lane A 1,1,0,0,1,0 repeating.
